// File: rtl/push_channel_receiver_pkg.sv
// Shared types and default parameters for the push-channel receiver.
// The FSM state encoding lives here so the top level and any checker
// agree on a single definition.
package push_rx_pkg;

   // Receiver handshake states.
   //   RESYNC   : waiting out the synchroniser after reset and for req to be low
   //   IDLE     : ready to accept a new request
   //   WAIT_LOW : request acknowledged, waiting for the return-to-zero phase
   typedef enum logic [1:0] {
      RESYNC   = 2'd0,
      IDLE     = 2'd1,
      WAIT_LOW = 2'd2
   } rx_state_t;

   localparam int DEF_WIDTH       = 1;
   localparam int DEF_DEPTH       = 4;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/push_channel_receiver_if.sv
// Push channel (req/ack/data) plus the downstream valid/ready stream.
// The slave modport is the receiver's view; the master modport is the
// environment (handshake producer and downstream consumer).
interface push_channel_receiver_if
   import push_rx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             push_0r;
   logic             push_0a;
   logic [WIDTH-1:0] push_0d;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output push_0r,
      output push_0d,
      output out_ready,
      input  push_0a,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  push_0r,
      input  push_0d,
      input  out_ready,
      output push_0a,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/push_channel_receiver_fifo.sv
// First-word-fall-through circular buffer. Pointers carry one extra MSB
// so that equal low bits with differing MSBs means full, fully equal means
// empty. A write into a full buffer is allowed when a pop happens on the
// same edge, since the freed slot is the one being written.
module push_rx_fifo
   import push_rx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   initialise,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   valid,
   output logic                   full,
   output logic [$clog2(DEPTH):0] fill
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];

   logic empty_s;
   logic full_s;
   logic do_pop_s;
   logic do_push_s;

   // Status flags and the qualified push/pop strobes.
   always_comb begin
      empty_s   = (wr_ptr_r == rd_ptr_r);
      full_s    = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                  (wr_ptr_r[AW] != rd_ptr_r[AW]);
      do_pop_s  = rd_en && !empty_s;
      do_push_s = wr_en && (!full_s || do_pop_s);
   end

   // Read and write pointers, wrapping modulo 2*DEPTH.
   always_ff @(posedge clk) begin
      if (initialise) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // Storage; cleared on reset so the head word reads zero afterwards.
   always_ff @(posedge clk) begin
      if (initialise) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
   assign valid   = !empty_s;
   assign full    = full_s;
   assign fill    = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/push_channel_receiver.sv
// Clocked consumer for a four-phase bundled-data push channel.
// The request is brought into the clock domain through a flop chain; the
// bundled data is sampled directly, relying on the producer holding it
// stable before raising req. Captured words go into a small FWFT FIFO.
// Backpressure is purely by withholding the acknowledge while full.
module push_channel_receiver
   import push_rx_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     initialise,
   push_channel_receiver_if.slave   bus,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [CNT_W-1:0]         xfer_count
);
   localparam int RCW = $clog2(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   req_s;

   rx_state_t              state_r;
   rx_state_t              state_next_s;
   logic [RCW-1:0]         resync_cnt_r;
   logic [RCW-1:0]         resync_cnt_next_s;
   logic                   ack_r;
   logic                   ack_next_s;
   logic                   capture_s;
   logic [CNT_W-1:0]       xfer_count_r;

   logic                   fifo_valid_s;
   logic                   fifo_full_s;
   logic                   pop_s;
   logic                   can_accept_s;

   // Request synchroniser: a plain shift chain, oldest stage is req_s.
   always_ff @(posedge clk) begin
      if (initialise) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], bus.push_0r};
      end
   end

   assign req_s = sync_r[SYNC_STAGES-1];

   // A pop frees a slot on the same edge, so a full FIFO may still accept.
   always_comb begin
      pop_s        = fifo_valid_s && bus.out_ready;
      can_accept_s = !fifo_full_s || pop_s;
   end

   // Handshake FSM next-state and registered-output decode.
   always_comb begin
      state_next_s      = state_r;
      resync_cnt_next_s = resync_cnt_r;
      ack_next_s        = ack_r;
      capture_s         = 1'b0;
      case (state_r)
         RESYNC: begin
            ack_next_s = 1'b0;
            if (resync_cnt_r != '0) begin
               resync_cnt_next_s = resync_cnt_r - RCW'(1);
            end else begin
               resync_cnt_next_s = resync_cnt_r;
            end
            // Leaving only with req low avoids re-capturing a handshake
            // that was in flight when reset hit.
            if ((resync_cnt_r == '0) && !req_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RESYNC;
            end
         end
         IDLE: begin
            if (req_s && can_accept_s) begin
               capture_s    = 1'b1;
               ack_next_s   = 1'b1;
               state_next_s = WAIT_LOW;
            end else begin
               ack_next_s   = 1'b0;
               state_next_s = IDLE;
            end
         end
         WAIT_LOW: begin
            if (!req_s) begin
               ack_next_s   = 1'b0;
               state_next_s = IDLE;
            end else begin
               ack_next_s   = 1'b1;
               state_next_s = WAIT_LOW;
            end
         end
         default: begin
            ack_next_s   = 1'b0;
            state_next_s = RESYNC;
         end
      endcase
   end

   // FSM state, resync counter and acknowledge registers.
   always_ff @(posedge clk) begin
      if (initialise) begin
         state_r      <= RESYNC;
         resync_cnt_r <= RCW'(SYNC_STAGES);
         ack_r        <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         resync_cnt_r <= resync_cnt_next_s;
         ack_r        <= ack_next_s;
      end
   end

   // Completed-capture counter, wrapping naturally at its width.
   always_ff @(posedge clk) begin
      if (initialise) begin
         xfer_count_r <= '0;
      end else if (capture_s) begin
         xfer_count_r <= xfer_count_r + CNT_W'(1);
      end else begin
         xfer_count_r <= xfer_count_r;
      end
   end

   push_rx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .initialise (initialise),
      .wr_en      (capture_s),
      .wr_data    (bus.push_0d),
      .rd_en      (bus.out_ready),
      .rd_data    (bus.out_data),
      .valid      (fifo_valid_s),
      .full       (fifo_full_s),
      .fill       (fill)
   );

   assign bus.push_0a   = ack_r;
   assign bus.out_valid = fifo_valid_s;
   assign xfer_count    = xfer_count_r;

endmodule

// File: tb/tb_push_channel_receiver.sv
// Self-checking bench: a queue-based behavioural model of the receiver is
// stepped on every rising edge and compared on every falling edge, with a
// set of directed scenarios pinning literal values, then randomised
// producer/consumer timing. A second instance with a 4-bit counter shares
// the stimulus so counter wrap is exercised cheaply.
`timescale 1ns/1ps
module tb_push_channel_receiver;
   import push_rx_pkg::*;

   localparam int WIDTH   = 8;
   localparam int DEPTH   = 4;
   localparam int SYNC    = 2;
   localparam int CNT_W   = 16;
   localparam int CNT_W_S = 4;

   logic clk = 1'b0;
   logic initialise;
   always #5 clk = ~clk;

   push_channel_receiver_if #(.WIDTH(WIDTH)) bus ();
   push_channel_receiver_if #(.WIDTH(WIDTH)) bus_w ();

   logic [$clog2(DEPTH):0] fill;
   logic [$clog2(DEPTH):0] fill_w;
   logic [CNT_W-1:0]       xfer_count;
   logic [CNT_W_S-1:0]     xfer_count_w;

   push_channel_receiver #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .initialise(initialise), .bus(bus),
      .fill(fill), .xfer_count(xfer_count)
   );

   push_channel_receiver #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W_S)
   ) dut_w (
      .clk(clk), .initialise(initialise), .bus(bus_w),
      .fill(fill_w), .xfer_count(xfer_count_w)
   );

   assign bus_w.push_0r   = bus.push_0r;
   assign bus_w.push_0d   = bus.push_0d;
   assign bus_w.out_ready = bus.out_ready;

   int vectors = 0;
   int miscompares = 0;

   // ---------------- behavioural model ----------------
   logic [WIDTH-1:0] m_q[$];    // words held by the receiver, head first
   bit               m_hist[$]; // push_0r as sampled on the last SYNC edges
   int               m_count;
   bit               m_ack;
   bit               m_armed;   // has reached the idle/accepting regime
   int               m_resync;
   bit               m_live = 1'b0;

   task automatic model_step();
      bit pop_b;
      bit rs;
      bit cap;
      if (initialise === 1'b1) begin
         m_q.delete();
         m_hist.delete();
         for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
         m_count  = 0;
         m_ack    = 1'b0;
         m_armed  = 1'b0;
         m_resync = SYNC;
         m_live   = 1'b1;
         return;
      end
      if (!m_live) return;
      pop_b = (m_q.size() > 0) && (bus.out_ready === 1'b1);
      rs    = m_hist[0];
      cap   = 1'b0;
      if (!m_armed) begin
         if (m_resync == 0 && !rs) m_armed = 1'b1;
         if (m_resync > 0) m_resync--;
      end else if (!m_ack) begin
         if (rs && (m_q.size() < DEPTH || pop_b)) cap = 1'b1;
      end else if (!rs) begin
         m_ack = 1'b0;
      end
      if (pop_b) void'(m_q.pop_front());
      if (cap) begin
         m_q.push_back(bus.push_0d);
         m_ack = 1'b1;
         m_count++;
      end
      void'(m_hist.pop_front());
      m_hist.push_back(bus.push_0r);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   initial forever begin
      @(negedge clk);
      if (m_live) begin
         check("push_0a", 64'(bus.push_0a), 64'(m_ack));
         check("out_valid", 64'(bus.out_valid), 64'(m_q.size() > 0));
         check("fill", 64'(fill), 64'(m_q.size()));
         check("xfer_count", 64'(xfer_count), 64'(m_count % 65536));
         check("xfer_count_w", 64'(xfer_count_w), 64'(m_count % 16));
         if (m_q.size() > 0) check("out_data", 64'(bus.out_data), 64'(m_q[0]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_ack(input logic val, input string name);
      int n = 0;
      while (bus.push_0a !== val && n < 300) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (bus.push_0a !== val) begin
         miscompares++;
         $display("FAIL %s timeout: push_0a=%b, required %b", name, bus.push_0a, val);
      end
   endtask

   task automatic handshake(input logic [WIDTH-1:0] d, input int maxd);
      repeat ($urandom_range(maxd, 0)) @(negedge clk);
      bus.push_0d = d;
      repeat ($urandom_range(maxd, 0)) @(negedge clk);
      bus.push_0r = 1'b1;
      @(negedge clk);
      wait_ack(1'b1, "ack_rise");
      repeat ($urandom_range(maxd, 0)) @(negedge clk);
      bus.push_0r = 1'b0;
      @(negedge clk);
      wait_ack(1'b0, "ack_fall");
   endtask

   task automatic do_reset();
      @(negedge clk);
      initialise = 1'b1;
      @(negedge clk);
      initialise = 1'b0;
   endtask

   logic [WIDTH-1:0] drain_exp [4];
   bit rnd_done;

   initial begin
      initialise    = 1'b1;
      bus.push_0r   = 1'b0;
      bus.push_0d   = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      initialise = 1'b0;

      // Reset values
      check("rst_push_0a", 64'(bus.push_0a), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_fill", 64'(fill), 64'd0);
      check("rst_xfer", 64'(xfer_count), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);

      // Single handshake latency: ack at 3rd edge after req rises and falls
      repeat (5) @(negedge clk);
      bus.push_0d = 8'd1;
      bus.push_0r = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("lat_ack_early", 64'(bus.push_0a), 64'd0);
      @(negedge clk);
      check("lat_ack", 64'(bus.push_0a), 64'd1);
      check("lat_valid", 64'(bus.out_valid), 64'd1);
      check("lat_data", 64'(bus.out_data), 64'd1);
      check("lat_xfer", 64'(xfer_count), 64'd1);
      bus.push_0r = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("lat_fall_early", 64'(bus.push_0a), 64'd1);
      @(negedge clk);
      check("lat_fall", 64'(bus.push_0a), 64'd0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("lat_drained", 64'(fill), 64'd0);

      // Fill to full, fifth request blocked until a pop frees a slot
      handshake(8'd1, 0);
      handshake(8'd0, 0);
      handshake(8'd1, 0);
      handshake(8'd1, 0);
      check("full_fill", 64'(fill), 64'd4);
      bus.push_0d = 8'd7;
      bus.push_0r = 1'b1;
      repeat (20) @(negedge clk);
      check("full_blocked", 64'(bus.push_0a), 64'd0);
      check("full_head", 64'(bus.out_data), 64'd1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("full_unblock_ack", 64'(bus.push_0a), 64'd1);
      check("full_unblock_fill", 64'(fill), 64'd4);
      bus.push_0r = 1'b0;
      @(negedge clk);
      wait_ack(1'b0, "full_release");
      drain_exp[0] = 8'd0;
      drain_exp[1] = 8'd1;
      drain_exp[2] = 8'd1;
      drain_exp[3] = 8'd7;
      for (int i = 0; i < 4; i++) begin
         check("drain_order", 64'(bus.out_data), 64'(drain_exp[i]));
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
      end
      check("drain_empty", 64'(fill), 64'd0);

      // Simultaneous pop and capture at fill=2
      handshake(8'd1, 0);
      handshake(8'd2, 0);
      bus.push_0d = 8'd3;
      bus.push_0r = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("simul_fill", 64'(fill), 64'd2);
      check("simul_data", 64'(bus.out_data), 64'd2);
      check("simul_ack", 64'(bus.push_0a), 64'd1);
      bus.push_0r = 1'b0;
      @(negedge clk);
      wait_ack(1'b0, "simul_release");
      bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);
      bus.out_ready = 1'b0;

      // Reset while in WAIT_LOW with req held high
      bus.push_0d = 8'd9;
      bus.push_0r = 1'b1;
      @(negedge clk);
      wait_ack(1'b1, "pre_reset_ack");
      do_reset();
      check("midrst_ack", 64'(bus.push_0a), 64'd0);
      check("midrst_fill", 64'(fill), 64'd0);
      repeat (20) @(negedge clk);
      check("midrst_hold_ack", 64'(bus.push_0a), 64'd0);
      check("midrst_hold_fill", 64'(fill), 64'd0);
      check("midrst_hold_xfer", 64'(xfer_count), 64'd0);
      bus.push_0r = 1'b0;
      repeat (6) @(negedge clk);
      bus.push_0r = 1'b1;
      @(negedge clk);
      wait_ack(1'b1, "post_reset_ack");
      check("midrst_new_data", 64'(bus.out_data), 64'd9);
      check("midrst_new_xfer", 64'(xfer_count), 64'd1);
      bus.push_0r = 1'b0;
      @(negedge clk);
      wait_ack(1'b0, "post_reset_release");

      // Counter wrap on the 4-bit instance: 15 more transfers make 16
      bus.out_ready = 1'b1;
      for (int i = 0; i < 15; i++) handshake(WIDTH'(i + 16), 0);
      bus.out_ready = 1'b0;
      check("wrap_small", 64'(xfer_count_w), 64'd0);
      check("wrap_wide", 64'(xfer_count), 64'd16);

      // Randomised producer and consumer timing
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) handshake(WIDTH'($urandom), 10);
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(negedge clk);
               bus.out_ready = ($urandom_range(1, 0) == 1);
            end
         end
      join
      bus.out_ready = 1'b1;
      repeat (8) @(negedge clk);
      bus.out_ready = 1'b0;
      check("rnd_xfer_total", 64'(xfer_count), 64'd166);
      check("rnd_drained", 64'(fill), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
